// File: rtl/br_stack_if.sv
// Dispatch-side bundle for the branch checkpoint stack: push, CDB, resolve inputs
// and the tag/mask/recovery outputs. The master drives requests; the slave is br_stack.
`ifndef BR_STATE_W
`define BR_STATE_W    2
`define BR_PR_WRONG   2'd1
`define BR_PR_CORRECT 2'd2
`endif

interface br_stack_if #(
  parameter int DEPTH    = 4,
  parameter int FL_PTR_W = 5
);
  logic                   push_en_i;
  logic [31:0][6:0]       mt_bak_data_i;
  logic [FL_PTR_W-1:0]    fl_head_i;
  logic                   cdb_en_i;
  logic [5:0]             cdb_preg_i;
  logic                   br_resolve_en_i;
  logic [DEPTH-1:0]       br_resolve_tag_i;
  logic [`BR_STATE_W-1:0] branch_state_i;

  logic                   full_o;
  logic [DEPTH-1:0]       br_tag_o;
  logic [DEPTH-1:0]       br_mask_o;
  logic [31:0][6:0]       rc_mt_all_data_o;
  logic [FL_PTR_W-1:0]    rc_fl_head_o;
  logic [DEPTH-1:0]       squash_mask_o;

  modport master (
    output push_en_i, mt_bak_data_i, fl_head_i, cdb_en_i, cdb_preg_i,
           br_resolve_en_i, br_resolve_tag_i, branch_state_i,
    input  full_o, br_tag_o, br_mask_o, rc_mt_all_data_o, rc_fl_head_o, squash_mask_o
  );

  modport slave (
    input  push_en_i, mt_bak_data_i, fl_head_i, cdb_en_i, cdb_preg_i,
           br_resolve_en_i, br_resolve_tag_i, branch_state_i,
    output full_o, br_tag_o, br_mask_o, rc_mt_all_data_o, rc_fl_head_o, squash_mask_o
  );
endinterface

// File: rtl/br_stack.sv
// Branch checkpoint stack: one map-table snapshot and free-list head per unresolved
// branch, returned in the same cycle on a mispredict, with ready bits kept live from the CDB.
module br_stack #(
  parameter int DEPTH    = 4,
  parameter int FL_PTR_W = 5
) (
  input logic       clk,
  input logic       rst,
  br_stack_if.slave bus
);
  typedef logic [31:0][6:0] snap_t;

  logic [DEPTH-1:0]    valid_q, valid_d;
  snap_t               data_q     [DEPTH];
  snap_t               data_d     [DEPTH];
  logic [FL_PTR_W-1:0] fl_head_q  [DEPTH];
  logic [FL_PTR_W-1:0] fl_head_d  [DEPTH];
  logic [DEPTH-1:0]    dep_mask_q [DEPTH];
  logic [DEPTH-1:0]    dep_mask_d [DEPTH];

  logic [DEPTH-1:0]    res_tag, clr_tag, squash, alloc_oh;
  logic                tag_onehot, res_valid, res_wrong, res_correct, full, push_ok;
  snap_t               rc_sel;
  logic [FL_PTR_W-1:0] rc_head;

  function automatic snap_t cdb_apply(input snap_t s, input logic en, input logic [5:0] preg);
    snap_t r;
    r = s;
    for (int e = 0; e < 32; e++) begin
      if (en && (s[e][5:0] == preg)) r[e][6] = 1'b1;
    end
    return r;
  endfunction

  // A resolve only counts for a one-hot tag that names a live slot.
  always_comb begin
    res_tag     = bus.br_resolve_tag_i;
    tag_onehot  = (res_tag != '0) && ((res_tag & (res_tag - DEPTH'(1))) == '0);
    res_valid   = bus.br_resolve_en_i && tag_onehot && ((res_tag & valid_q) != '0);
    res_wrong   = res_valid && (bus.branch_state_i == `BR_PR_WRONG);
    res_correct = res_valid && (bus.branch_state_i == `BR_PR_CORRECT);
    clr_tag     = res_correct ? res_tag : '0;
    squash      = '0;
    if (res_wrong) begin
      squash = res_tag;
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && ((dep_mask_q[i] & res_tag) != '0)) squash[i] = 1'b1;
      end
    end
  end

  // Allocation looks at pre-resolve valid bits, so a slot freed this cycle is not reused.
  always_comb begin
    full     = &valid_q;
    alloc_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
      end
    end
    push_ok = bus.push_en_i && !full && !res_wrong && !rst;
  end

  always_comb begin
    rc_sel  = '0;
    rc_head = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (res_tag[i]) begin
        rc_sel  = rc_sel | data_q[i];
        rc_head = rc_head | fl_head_q[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q & ~clr_tag & ~squash;
    if (push_ok) valid_d = valid_d | alloc_oh;
    for (int i = 0; i < DEPTH; i++) begin
      data_d[i]     = valid_q[i] ? cdb_apply(data_q[i], bus.cdb_en_i, bus.cdb_preg_i) : data_q[i];
      fl_head_d[i]  = fl_head_q[i];
      dep_mask_d[i] = dep_mask_q[i] & ~clr_tag;
      if (push_ok && alloc_oh[i]) begin
        data_d[i]     = cdb_apply(bus.mt_bak_data_i, bus.cdb_en_i, bus.cdb_preg_i);
        fl_head_d[i]  = bus.fl_head_i;
        dep_mask_d[i] = valid_q & ~clr_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]     <= '0;
        fl_head_q[i]  <= '0;
        dep_mask_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]     <= data_d[i];
        fl_head_q[i]  <= fl_head_d[i];
        dep_mask_q[i] <= dep_mask_d[i];
      end
    end
  end

  // Reset forces every output quiet, including the combinational recovery path.
  assign bus.full_o           = !rst && full;
  assign bus.br_tag_o         = push_ok ? alloc_oh : '0;
  assign bus.br_mask_o        = rst ? '0 : valid_q;
  assign bus.squash_mask_o    = rst ? '0 : squash;
  assign bus.rc_mt_all_data_o = (res_wrong && !rst) ? cdb_apply(rc_sel, bus.cdb_en_i, bus.cdb_preg_i) : '0;
  assign bus.rc_fl_head_o     = (res_wrong && !rst) ? rc_head : '0;
endmodule

// File: tb/tb_br_stack.sv
// Directed bench for br_stack: a table of per-cycle vectors for allocation/resolve,
// plus hand-written sequences for CDB ready tracking and reset priority.
`ifndef BR_STATE_W
`define BR_STATE_W    2
`define BR_PR_WRONG   2'd1
`define BR_PR_CORRECT 2'd2
`endif

module tb_br_stack;
  localparam int DEPTH    = 4;
  localparam int FL_PTR_W = 5;
  localparam logic [1:0] W = `BR_PR_WRONG;
  localparam logic [1:0] C = `BR_PR_CORRECT;
  localparam int NV = 22;

  typedef logic [31:0][6:0] snap_t;

  typedef struct {
    logic       push;
    int         key;
    logic [4:0] head;
    logic       res_en;
    logic [3:0] tag;
    logic [1:0] st;
    logic [3:0] exp_tag;
    logic       exp_full;
    logic [3:0] exp_mask;
    logic [3:0] exp_squash;
    logic [4:0] exp_head;
    int         exp_key;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    passed = 0;
  vec_t  vecs [NV];
  snap_t s, exp_s;

  br_stack_if #(.DEPTH(DEPTH), .FL_PTR_W(FL_PTR_W)) bus ();
  br_stack #(.DEPTH(DEPTH), .FL_PTR_W(FL_PTR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic snap_t mkSnap(input int key);
    snap_t r;
    for (int e = 0; e < 32; e++) r[e] = {1'b0, 6'(e + key * 7)};
    return r;
  endfunction

  function automatic vec_t mkVec(input logic push, input int key, input logic [4:0] head,
                                 input logic res_en, input logic [3:0] tag, input logic [1:0] st,
                                 input logic [3:0] e_tag, input logic e_full, input logic [3:0] e_mask,
                                 input logic [3:0] e_sq, input logic [4:0] e_head, input int e_key);
    vec_t v;
    v.push = push; v.key = key; v.head = head; v.res_en = res_en; v.tag = tag; v.st = st;
    v.exp_tag = e_tag; v.exp_full = e_full; v.exp_mask = e_mask; v.exp_squash = e_sq;
    v.exp_head = e_head; v.exp_key = e_key;
    return v;
  endfunction

  task automatic setIdle();
    bus.push_en_i        = 1'b0;
    bus.mt_bak_data_i    = '0;
    bus.fl_head_i        = '0;
    bus.cdb_en_i         = 1'b0;
    bus.cdb_preg_i       = '0;
    bus.br_resolve_en_i  = 1'b0;
    bus.br_resolve_tag_i = '0;
    bus.branch_state_i   = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    setIdle();
    bus.push_en_i        = v.push;
    bus.mt_bak_data_i    = mkSnap(v.key);
    bus.fl_head_i        = v.head;
    bus.br_resolve_en_i  = v.res_en;
    bus.br_resolve_tag_i = v.tag;
    bus.branch_state_i   = v.st;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic checkSnap(input string name, input snap_t act, input snap_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    setIdle();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    //             push key head  ren tag  st   etag full mask sq   ehead ekey
    vecs[0]  = mkVec(1, 0, 5'd7,  0, 4'h0, 0, 4'h1, 0, 4'h0, 4'h0, 5'd0,  -1);
    vecs[1]  = mkVec(0, 0, 5'd0,  0, 4'h0, 0, 4'h0, 0, 4'h1, 4'h0, 5'd0,  -1);
    vecs[2]  = mkVec(1, 1, 5'd9,  0, 4'h0, 0, 4'h2, 0, 4'h1, 4'h0, 5'd0,  -1);
    vecs[3]  = mkVec(1, 2, 5'd11, 0, 4'h0, 0, 4'h4, 0, 4'h3, 4'h0, 5'd0,  -1);
    vecs[4]  = mkVec(1, 3, 5'd13, 0, 4'h0, 0, 4'h8, 0, 4'h7, 4'h0, 5'd0,  -1);
    vecs[5]  = mkVec(1, 4, 5'd15, 0, 4'h0, 0, 4'h0, 1, 4'hF, 4'h0, 5'd0,  -1);
    vecs[6]  = mkVec(0, 0, 5'd0,  1, 4'h2, W, 4'h0, 1, 4'hF, 4'hE, 5'd9,   1);
    vecs[7]  = mkVec(0, 0, 5'd0,  0, 4'h0, 0, 4'h0, 0, 4'h1, 4'h0, 5'd0,  -1);
    vecs[8]  = mkVec(1, 5, 5'd20, 0, 4'h0, 0, 4'h2, 0, 4'h1, 4'h0, 5'd0,  -1);
    vecs[9]  = mkVec(1, 6, 5'd21, 1, 4'h1, C, 4'h4, 0, 4'h3, 4'h0, 5'd0,  -1);
    vecs[10] = mkVec(0, 0, 5'd0,  0, 4'h0, 0, 4'h0, 0, 4'h6, 4'h0, 5'd0,  -1);
    vecs[11] = mkVec(1, 8, 5'd22, 0, 4'h0, 0, 4'h1, 0, 4'h6, 4'h0, 5'd0,  -1);
    vecs[12] = mkVec(0, 0, 5'd0,  1, 4'h1, W, 4'h0, 0, 4'h7, 4'h1, 5'd22,  8);
    vecs[13] = mkVec(0, 0, 5'd0,  0, 4'h0, 0, 4'h0, 0, 4'h6, 4'h0, 5'd0,  -1);
    vecs[14] = mkVec(0, 0, 5'd0,  1, 4'h6, W, 4'h0, 0, 4'h6, 4'h0, 5'd0,  -1);
    vecs[15] = mkVec(0, 0, 5'd0,  1, 4'h1, W, 4'h0, 0, 4'h6, 4'h0, 5'd0,  -1);
    vecs[16] = mkVec(1, 7, 5'd3,  1, 4'h4, W, 4'h0, 0, 4'h6, 4'h4, 5'd21,  6);
    vecs[17] = mkVec(0, 0, 5'd0,  0, 4'h0, 0, 4'h0, 0, 4'h2, 4'h0, 5'd0,  -1);
    vecs[18] = mkVec(0, 0, 5'd0,  1, 4'h2, C, 4'h0, 0, 4'h2, 4'h0, 5'd0,  -1);
    vecs[19] = mkVec(0, 0, 5'd0,  0, 4'h0, 0, 4'h0, 0, 4'h0, 4'h0, 5'd0,  -1);
    vecs[20] = mkVec(0, 0, 5'd0,  1, 4'h4, C, 4'h0, 0, 4'h0, 4'h0, 5'd0,  -1);
    vecs[21] = mkVec(1, 9, 5'd30, 0, 4'h0, 0, 4'h1, 0, 4'h0, 4'h0, 5'd0,  -1);

    doReset();
    checkOutput("reset br_mask", 32'(bus.br_mask_o), 32'h0);
    checkOutput("reset full", 32'(bus.full_o), 32'h0);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d br_tag", i), 32'(bus.br_tag_o), 32'(vecs[i].exp_tag));
      checkOutput($sformatf("v%0d full", i), 32'(bus.full_o), 32'(vecs[i].exp_full));
      checkOutput($sformatf("v%0d br_mask", i), 32'(bus.br_mask_o), 32'(vecs[i].exp_mask));
      checkOutput($sformatf("v%0d squash", i), 32'(bus.squash_mask_o), 32'(vecs[i].exp_squash));
      checkOutput($sformatf("v%0d rc_head", i), 32'(bus.rc_fl_head_o), 32'(vecs[i].exp_head));
      exp_s = (vecs[i].exp_key < 0) ? '0 : mkSnap(vecs[i].exp_key);
      checkSnap($sformatf("v%0d rc_data", i), bus.rc_mt_all_data_o, exp_s);
      step();
    end

    // CDB broadcast while the checkpoint sits in the stack
    doReset();
    s = mkSnap(0);
    s[5] = {1'b0, 6'd40};
    bus.push_en_i = 1'b1; bus.mt_bak_data_i = s; bus.fl_head_i = 5'd4;
    step();
    setIdle();
    bus.cdb_en_i = 1'b1; bus.cdb_preg_i = 6'd40;
    step();
    setIdle();
    bus.br_resolve_en_i = 1'b1; bus.br_resolve_tag_i = 4'h1; bus.branch_state_i = W;
    #1;
    exp_s = s;
    exp_s[5] = 7'h68;
    checkSnap("cdb stored rc_data", bus.rc_mt_all_data_o, exp_s);
    checkOutput("cdb stored rc_head", 32'(bus.rc_fl_head_o), 32'd4);
    checkOutput("cdb stored squash", 32'(bus.squash_mask_o), 32'h1);
    step();
    setIdle();

    // CDB broadcast in the same cycle as the mispredict
    doReset();
    bus.push_en_i = 1'b1; bus.mt_bak_data_i = s; bus.fl_head_i = 5'd6;
    step();
    setIdle();
    bus.br_resolve_en_i = 1'b1; bus.br_resolve_tag_i = 4'h1; bus.branch_state_i = W;
    bus.cdb_en_i = 1'b1; bus.cdb_preg_i = 6'd40;
    #1;
    checkSnap("cdb bypass rc_data", bus.rc_mt_all_data_o, exp_s);
    checkOutput("cdb bypass rc_head", 32'(bus.rc_fl_head_o), 32'd6);
    step();
    setIdle();

    // CDB broadcast in the same cycle as the push
    doReset();
    bus.push_en_i = 1'b1; bus.mt_bak_data_i = mkSnap(0); bus.fl_head_i = 5'd2;
    bus.cdb_en_i = 1'b1; bus.cdb_preg_i = 6'd3;
    step();
    setIdle();
    step();
    bus.br_resolve_en_i = 1'b1; bus.br_resolve_tag_i = 4'h1; bus.branch_state_i = W;
    #1;
    exp_s = mkSnap(0);
    exp_s[3] = 7'h43;
    checkSnap("cdb push rc_data", bus.rc_mt_all_data_o, exp_s);
    step();
    setIdle();

    // Reset asserted together with push and mispredict
    bus.push_en_i = 1'b1; bus.mt_bak_data_i = mkSnap(1);
    step();
    bus.mt_bak_data_i = mkSnap(2);
    step();
    setIdle();
    #1;
    checkOutput("pre-reset br_mask", 32'(bus.br_mask_o), 32'h3);
    rst = 1'b1;
    bus.push_en_i = 1'b1; bus.mt_bak_data_i = mkSnap(3); bus.fl_head_i = 5'd9;
    bus.br_resolve_en_i = 1'b1; bus.br_resolve_tag_i = 4'h1; bus.branch_state_i = W;
    #1;
    checkOutput("in-reset br_tag", 32'(bus.br_tag_o), 32'h0);
    checkOutput("in-reset squash", 32'(bus.squash_mask_o), 32'h0);
    checkOutput("in-reset rc_head", 32'(bus.rc_fl_head_o), 32'h0);
    checkSnap("in-reset rc_data", bus.rc_mt_all_data_o, '0);
    checkOutput("in-reset br_mask", 32'(bus.br_mask_o), 32'h0);
    step();
    rst = 1'b0;
    setIdle();
    #1;
    checkOutput("post-reset br_mask", 32'(bus.br_mask_o), 32'h0);
    checkOutput("post-reset full", 32'(bus.full_o), 32'h0);
    bus.push_en_i = 1'b1; bus.mt_bak_data_i = mkSnap(4);
    #1;
    checkOutput("post-reset br_tag", 32'(bus.br_tag_o), 32'h1);
    step();
    setIdle();
    #1;
    checkOutput("post-reset push mask", 32'(bus.br_mask_o), 32'h1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
